// File: rtl/logic_stream_pkg.sv
// Shared types for the logic stream unit: operation/mode encodings, FSM states, fold-op helper.
package logic_stream_pkg;

   typedef enum logic [1:0] {
      OP_AND  = 2'd0,
      OP_OR   = 2'd1,
      OP_XOR  = 2'd2,
      OP_NAND = 2'd3
   } op_e;

   typedef enum logic {
      MODE_ELEM   = 1'b0,
      MODE_REDUCE = 1'b1
   } mode_e;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_ACCUM = 1'b1
   } state_e;

   // NAND beats are already inverted, so the block fold for NAND is a plain AND.
   function automatic op_e fold_op(input op_e op);
      return (op == OP_NAND) ? OP_AND : op;
   endfunction

endpackage

// File: rtl/logic_op.sv
// Bitwise two-operand logic function, selected by op_i.
module logic_op
   import logic_stream_pkg::*;
#(
   parameter int unsigned WIDTH = 16
) (
   input  logic [1:0]       op_i,
   input  logic [WIDTH-1:0] x_i,
   input  logic [WIDTH-1:0] y_i,
   output logic [WIDTH-1:0] z_o
);

   op_e op;
   assign op = op_e'(op_i);

   // Per-bit operation select; no carries between bits.
   always_comb begin
      z_o = '0;
      case (op)
         OP_AND:  z_o = x_i & y_i;
         OP_OR:   z_o = x_i | y_i;
         OP_XOR:  z_o = x_i ^ y_i;
         OP_NAND: z_o = ~(x_i & y_i);
         default: z_o = '0;
      endcase
   end

endmodule

// File: rtl/logic_stream_unit.sv
// Streaming bitwise logic unit: elementwise results or a fold over BLOCK_LEN beats,
// with a single registered output stage and valid/ready handshakes on both sides.
module logic_stream_unit
   import logic_stream_pkg::*;
#(
   parameter int unsigned WIDTH     = 16,
   parameter int unsigned BLOCK_LEN = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [1:0]                op_i,
   input  logic                      mode_i,
   input  logic                      s_valid,
   output logic                      s_ready,
   input  logic [WIDTH-1:0]          a_i,
   input  logic [WIDTH-1:0]          b_i,
   output logic                      m_valid,
   input  logic                      m_ready,
   output logic [WIDTH-1:0]          y_o,
   output logic [$clog2(BLOCK_LEN):0] beat_cnt_o
);

   localparam int unsigned      CNT_W    = $clog2(BLOCK_LEN) + 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BLOCK_LEN - 1);

   state_e           state_q, state_d;
   op_e              op_q, op_d;
   mode_e            mode_q, mode_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] y_q, y_d;
   logic             m_valid_q, m_valid_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             run_q;

   op_e              eff_op_c;
   mode_e            eff_mode_c;
   logic             first_c, last_c, out_free_c, accept_c;
   logic [1:0]       f_op_c, g_op_c;
   logic [WIDTH-1:0] f_z_c, g_z_c, beat_val_c;

   // Op/mode come from the inputs on the first beat of a block, from the latch afterwards.
   assign first_c    = (state_q == ST_IDLE);
   assign eff_op_c   = first_c ? op_e'(op_i) : op_q;
   assign eff_mode_c = first_c ? mode_e'(mode_i) : mode_q;
   assign f_op_c     = 2'(eff_op_c);
   assign g_op_c     = 2'(fold_op(op_q));

   logic_op #(.WIDTH(WIDTH)) u_beat_op (
      .op_i (f_op_c),
      .x_i  (a_i),
      .y_i  (b_i),
      .z_o  (f_z_c)
   );

   logic_op #(.WIDTH(WIDTH)) u_fold_op (
      .op_i (g_op_c),
      .x_i  (acc_q),
      .y_i  (f_z_c),
      .z_o  (g_z_c)
   );

   assign beat_val_c = first_c ? f_z_c : g_z_c;
   assign last_c     = (eff_mode_c == MODE_ELEM) || (!first_c && (cnt_q == LAST_CNT));
   assign out_free_c = !m_valid_q || m_ready;
   // Only a beat that produces a result has to wait for the output register.
   assign s_ready    = run_q && (out_free_c || !last_c);
   assign accept_c   = s_valid && s_ready;

   assign m_valid    = m_valid_q;
   assign y_o        = y_q;
   assign beat_cnt_o = cnt_q;

   // Next-state: hand-off, accumulate, or complete a block into the output register.
   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      mode_d    = mode_q;
      acc_d     = acc_q;
      y_d       = y_q;
      cnt_d     = cnt_q;
      m_valid_d = m_valid_q && !m_ready;
      if (accept_c) begin
         op_d   = eff_op_c;
         mode_d = eff_mode_c;
         if (last_c) begin
            y_d       = beat_val_c;
            m_valid_d = 1'b1;
            acc_d     = '0;
            cnt_d     = '0;
            state_d   = ST_IDLE;
         end else begin
            acc_d   = beat_val_c;
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = ST_ACCUM;
         end
      end
   end

   // State registers; run_q holds off input acceptance until the first edge after reset release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         op_q      <= OP_AND;
         mode_q    <= MODE_ELEM;
         acc_q     <= '0;
         y_q       <= '0;
         m_valid_q <= 1'b0;
         cnt_q     <= '0;
         run_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         mode_q    <= mode_d;
         acc_q     <= acc_d;
         y_q       <= y_d;
         m_valid_q <= m_valid_d;
         cnt_q     <= cnt_d;
         run_q     <= 1'b1;
      end
   end

endmodule
